i_ap_sat_sub_acc: RTL and testbench

- Streaming saturating signed subtract/accumulate unit: z = sat(x_sel - y), where x_sel is either the input operand or an internal running accumulator.
- Complements the saturating adder in the vRBM datapath. Used for weight/bias decrement (w <- w - delta) and for contrastive-divergence differences.
- Same saturation convention as the adder: symmetric clamp to +Inf / -Inf.
- valid/ready on both sides; 1-cycle latency; 1-entry skid buffer.

---
 rtl/i_ap_sat_sub_acc_pkg.sv | 19 +
 rtl/i_ap_sat_sub_acc_if.sv | 25 ++
 rtl/i_ap_sat_sub_acc_sub.sv | 20 ++
 rtl/i_ap_sat_sub_acc.sv | 96 +++++++++
 tb/tb_i_ap_sat_sub_acc.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i_ap_sat_sub_acc_pkg.sv
// vRBM fixed-point constants shared by the saturating add/sub datapath.
// Results clamp symmetrically to +Inf / -Inf.
package i_ap_sat_sub_acc_pkg;
  localparam int bitlength = 16;

  typedef logic [bitlength-1:0] word_t;

  localparam word_t Inf     = 16'b0111_1111_1111_1111;
  localparam word_t NEG_INF = ~Inf + 1'b1;

  // Bit positions inside the 2-bit {neg_ovf, pos_ovf} flag vector.
  localparam int SAT_POS_BIT = 0;
  localparam int SAT_NEG_BIT = 1;

  typedef struct packed {
    word_t      z;
    logic [1:0] sat;
  } result_t;
endpackage

// File: rtl/i_ap_sat_sub_acc_if.sv
// Operand/result stream bundle. Transfers occur on a rising edge where
// valid and ready are both high; valid never depends on ready.
interface i_ap_sat_sub_acc_if;
  import i_ap_sat_sub_acc_pkg::*;

  logic       in_valid;
  logic       in_ready;
  word_t      in_x;
  word_t      in_y;
  logic       in_acc;
  logic       out_valid;
  logic       out_ready;
  word_t      out_z;
  logic [1:0] out_sat;

  modport master (
    output in_valid, in_x, in_y, in_acc, out_ready,
    input  in_ready, out_valid, out_z, out_sat
  );

  modport slave (
    input  in_valid, in_x, in_y, in_acc, out_ready,
    output in_ready, out_valid, out_z, out_sat
  );
endinterface

// File: rtl/i_ap_sat_sub_acc_sub.sv
// Combinational saturating signed subtractor: z = sat(x - y).
// A non-overflowing -32768 result passes through unclamped.
module i_ap_sat_sub
  import i_ap_sat_sub_acc_pkg::*;
(
  input  word_t x,
  input  word_t y,
  output word_t z,
  output logic  pos_ovf,
  output logic  neg_ovf
);
  localparam int MSB = bitlength - 1;

  word_t tmp;

  assign tmp     = x - y;
  assign pos_ovf = !x[MSB] &  y[MSB] &  tmp[MSB];
  assign neg_ovf =  x[MSB] & !y[MSB] & !tmp[MSB];
  assign z       = pos_ovf ? Inf : (neg_ovf ? NEG_INF : tmp);
endmodule

// File: rtl/i_ap_sat_sub_acc.sv
// Streaming saturating subtract/accumulate with 1-cycle latency and a
// 1-entry skid buffer; accumulator updates at accept so acc ops chain freely.
module i_ap_sat_sub_acc
  import i_ap_sat_sub_acc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  i_ap_sat_sub_acc_if.slave    bus,
  output word_t                acc_value,
  output logic [CNT_W-1:0]     sat_count
);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  result_t out_q;
  result_t skid_q;
  logic    out_valid_q;
  logic    skid_valid_q;

  word_t   x_sel;
  word_t   diff;
  logic    pos_ovf;
  logic    neg_ovf;
  logic    accept;
  logic    sat_any;
  result_t res;

  assign x_sel   = clr ? '0 : (bus.in_acc ? acc_value : bus.in_x);
  assign accept  = bus.in_valid & bus.in_ready;
  assign sat_any = pos_ovf | neg_ovf;

  i_ap_sat_sub u_sub (
    .x       (x_sel),
    .y       (bus.in_y),
    .z       (diff),
    .pos_ovf (pos_ovf),
    .neg_ovf (neg_ovf)
  );

  always_comb begin
    res                  = '0;
    res.z                = diff;
    res.sat[SAT_POS_BIT] = pos_ovf;
    res.sat[SAT_NEG_BIT] = neg_ovf;
  end

  // in_ready is a pure register so out_ready never reaches it combinationally.
  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_z     = out_q.z;
  assign bus.out_sat   = out_q.sat;

  // Output/skid path. Accept is impossible while the skid is full, so the
  // skid-drain branch never competes with a new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= res;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= res;
      skid_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_value <= '0;
      sat_count <= '0;
    end else if (accept) begin
      acc_value <= res.z;
      if (clr)
        sat_count <= sat_any ? CNT_ONE : '0;
      else if (sat_any && sat_count != CNT_MAX)
        sat_count <= sat_count + CNT_ONE;
    end else if (clr) begin
      acc_value <= '0;
      sat_count <= '0;
    end
  end
endmodule

// File: tb/tb_i_ap_sat_sub_acc.sv
// Directed bench for i_ap_sat_sub_acc: subtract, saturation, accumulate
// chains, backpressure/skid ordering, clr and reset flush.
module tb_i_ap_sat_sub_acc;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [15:0]   acc_value;
  logic [CW-1:0] sat_count;

  int n_cmp  = 0;
  int n_fail = 0;

  i_ap_sat_sub_acc_if bus ();

  i_ap_sat_sub_acc #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .bus       (bus),
    .acc_value (acc_value),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y, input logic a);
    bus.in_valid = v;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_acc   = a;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; bus.out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    #3;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.out_z, bus.out_sat} !== {1'b0, 1'b1, 16'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_out got v=%b r=%b z=%h s=%b exp v=0 r=1 z=0000 s=00",
               bus.out_valid, bus.in_ready, bus.out_z, bus.out_sat);
    end
    n_cmp++;
    if ({acc_value, sat_count} !== {16'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_state got acc=%h cnt=%0d exp acc=0000 cnt=0", acc_value, sat_count);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_plain_sub();
    drive(1'b1, 16'd100, 16'd30, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    n_cmp++;
    if ({bus.out_valid, bus.out_z, bus.out_sat, acc_value} !== {1'b1, 16'd70, 2'b00, 16'd70}) begin
      n_fail++;
      $display("FAIL plain_sub got v=%b z=%h s=%b acc=%h exp v=1 z=0046 s=00 acc=0046",
               bus.out_valid, bus.out_z, bus.out_sat, acc_value);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] xs [5];
    logic [15:0] ys [5];
    logic [15:0] ez [5];
    logic [1:0]  es [5];
    logic [3:0]  ec [5];
    xs = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h1234};
    ys = '{16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF, 16'h0234};
    ez = '{16'h7FFF, 16'h8001, 16'h7FFF, 16'h8000, 16'h1000};
    es = '{2'b01,    2'b10,    2'b01,    2'b00,    2'b00};
    ec = '{4'd1,     4'd2,     4'd3,     4'd3,     4'd3};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, xs[i], ys[i], 1'b0);
      step();
      n_cmp++;
      if ({bus.out_valid, bus.out_z, bus.out_sat, sat_count} !== {1'b1, ez[i], es[i], ec[i]}) begin
        n_fail++;
        $display("FAIL sat_%0d got v=%b z=%h s=%b cnt=%0d exp v=1 z=%h s=%b cnt=%0d",
                 i, bus.out_valid, bus.out_z, bus.out_sat, sat_count, ez[i], es[i], ec[i]);
      end
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_acc_chain();
    logic [15:0] ez [5];
    ez = '{16'd10, 16'd7, 16'd4, 16'd1, 16'hFFFE};
    drive(1'b1, 16'd10, 16'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      drive(1'b1, 16'hDEAD, 16'd3, 1'b1);
      n_cmp++;
      if ({bus.out_valid, bus.out_z, acc_value} !== {1'b1, ez[i], ez[i]}) begin
        n_fail++;
        $display("FAIL acc_chain_%0d got v=%b z=%h acc=%h exp v=1 z=%h acc=%h",
                 i, bus.out_valid, bus.out_z, acc_value, ez[i], ez[i]);
      end
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 16'd5, 16'd1, 1'b0);
    step();
    n_cmp++;
    if ({bus.out_valid, bus.out_z, bus.in_ready} !== {1'b1, 16'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_a got v=%b z=%h rdy=%b exp v=1 z=0004 rdy=1", bus.out_valid, bus.out_z, bus.in_ready);
    end
    drive(1'b1, 16'd9, 16'd2, 1'b0);
    step();
    n_cmp++;
    if ({bus.out_valid, bus.out_z, bus.in_ready} !== {1'b1, 16'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_b_skid got v=%b z=%h rdy=%b exp v=1 z=0004 rdy=0", bus.out_valid, bus.out_z, bus.in_ready);
    end
    drive(1'b1, 16'd1, 16'd1, 1'b0);
    step();
    n_cmp++;
    if ({bus.out_valid, bus.out_z, bus.in_ready, acc_value} !== {1'b1, 16'd4, 1'b0, 16'd7}) begin
      n_fail++;
      $display("FAIL bp_c_stall got v=%b z=%h rdy=%b acc=%h exp v=1 z=0004 rdy=0 acc=0007",
               bus.out_valid, bus.out_z, bus.in_ready, acc_value);
    end
    bus.out_ready = 1'b1;
    step();
    n_cmp++;
    if ({bus.out_valid, bus.out_z, bus.in_ready} !== {1'b1, 16'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_drain_b got v=%b z=%h rdy=%b exp v=1 z=0007 rdy=1", bus.out_valid, bus.out_z, bus.in_ready);
    end
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    n_cmp++;
    if ({bus.out_valid, bus.out_z} !== {1'b1, 16'd0}) begin
      n_fail++;
      $display("FAIL bp_drain_c got v=%b z=%h exp v=1 z=0000", bus.out_valid, bus.out_z);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty got v=%b exp v=0", bus.out_valid);
    end
  endtask

  task automatic test_clr();
    drive(1'b1, 16'd50, 16'd0, 1'b0);
    step();
    n_cmp++;
    if ({acc_value, sat_count} !== {16'd50, 4'd3}) begin
      n_fail++;
      $display("FAIL clr_preload got acc=%h cnt=%0d exp acc=0032 cnt=3", acc_value, sat_count);
    end
    clr = 1'b1;
    drive(1'b1, 16'h1111, 16'd5, 1'b1);
    step();
    n_cmp++;
    if ({bus.out_z, acc_value, sat_count} !== {16'hFFFB, 16'hFFFB, 4'd0}) begin
      n_fail++;
      $display("FAIL clr_acc_op got z=%h acc=%h cnt=%0d exp z=fffb acc=fffb cnt=0", bus.out_z, acc_value, sat_count);
    end
    drive(1'b1, 16'h1111, 16'h8000, 1'b1);
    step();
    n_cmp++;
    if ({bus.out_z, bus.out_sat, acc_value, sat_count} !== {16'h7FFF, 2'b01, 16'h7FFF, 4'd1}) begin
      n_fail++;
      $display("FAIL clr_sat_op got z=%h s=%b acc=%h cnt=%0d exp z=7fff s=01 acc=7fff cnt=1",
               bus.out_z, bus.out_sat, acc_value, sat_count);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    step();
    clr = 1'b0;
    n_cmp++;
    if ({bus.out_z, acc_value, sat_count} !== {16'h7FFF, 16'h0, 4'd0}) begin
      n_fail++;
      $display("FAIL clr_idle got z=%h acc=%h cnt=%0d exp z=7fff acc=0000 cnt=0", bus.out_z, acc_value, sat_count);
    end
  endtask

  task automatic test_count_sticky();
    drive(1'b1, 16'h7FFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 17; i++) step();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    n_cmp++;
    if (sat_count !== 4'hF) begin
      n_fail++;
      $display("FAIL cnt_sticky got cnt=%0d exp cnt=15", sat_count);
    end
    step();
  endtask

  task automatic test_reset_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 16'd3, 16'd1, 1'b0);
    step();
    drive(1'b1, 16'd8, 16'd1, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.out_z} !== {1'b1, 1'b0, 16'd2}) begin
      n_fail++;
      $display("FAIL flush_pre got v=%b rdy=%b z=%h exp v=1 rdy=0 z=0002", bus.out_valid, bus.in_ready, bus.out_z);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.out_z, acc_value, sat_count} !== {1'b1 ^ 1'b1, 1'b1, 16'h0, 16'h0, 4'd0}) begin
      n_fail++;
      $display("FAIL flush_rst got v=%b rdy=%b z=%h acc=%h cnt=%0d exp v=0 rdy=1 z=0000 acc=0000 cnt=0",
               bus.out_valid, bus.in_ready, bus.out_z, acc_value, sat_count);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_after got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_plain_sub();
    test_saturation();
    test_acc_chain();
    test_backpressure();
    test_clr();
    test_count_sticky();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
